// File: rtl/turf_hold_scheduler_if.sv
// ---------------------------------------------------------------------------
// turf_hold_scheduler_if
//   Bundles the trigger/clear request inputs and the HOLD/status outputs of
//   turf_hold_scheduler. Clock and reset are not part of the bundle.
//
//   master : drives the requests, observes HOLD/status (register side / bench)
//   slave  : the scheduler itself
//
//   Signals (direction as seen by the scheduler):
//     trig_i      in   trigger request, one-cycle pulse
//     clr_evt_i   in   release oldest held buffer, one-cycle pulse
//     clr_all_i   in   synchronous master clear
//     disable_i   in   level, rejects triggers without counting them
//     pps_i       in   PPS pulse, synchronous to clk33
//     hold_o      out  HOLD mask, bit n = buffer n held
//     trig_ack_o  out  one-cycle pulse per accepted trigger
//     trig_buf_o  out  buffer index of the accepted trigger
//     full_o      out  all four buffers held
//     status_o    out  {dropped[15:0], 8'h00, 1'b0, count[2:0], hold[3:0]}
//     dead_o      out  dead-time cycles latched at the last PPS
// ---------------------------------------------------------------------------
interface turf_hold_scheduler_if;
    logic        trig_i;
    logic        clr_evt_i;
    logic        clr_all_i;
    logic        disable_i;
    logic        pps_i;
    logic [3:0]  hold_o;
    logic        trig_ack_o;
    logic [1:0]  trig_buf_o;
    logic        full_o;
    logic [31:0] status_o;
    logic [31:0] dead_o;

    modport master (
        output trig_i, clr_evt_i, clr_all_i, disable_i, pps_i,
        input  hold_o, trig_ack_o, trig_buf_o, full_o, status_o, dead_o
    );

    modport slave (
        input  trig_i, clr_evt_i, clr_all_i, disable_i, pps_i,
        output hold_o, trig_ack_o, trig_buf_o, full_o, status_o, dead_o
    );
endinterface

// File: rtl/turf_hold_scheduler.sv
// ---------------------------------------------------------------------------
// turf_hold_scheduler
//   Allocates and releases the four per-SURF HOLD buffers on the 33 MHz side
//   of the TURF. Accepted triggers claim buffers in round-robin order; each
//   event clear releases the oldest held buffer. After every accepted trigger
//   a holdoff window of HOLDOFF cycles ignores further triggers. Triggers
//   arriving while all buffers are held are counted (saturating) as dropped.
//
//   Parameters
//     HOLDOFF  holdoff length in clk33 cycles after an accepted trigger, 1..255
//
//   Ports
//     clk33_i  33 MHz system clock (only clock)
//     rst_n_i  asynchronous active-low reset
//     bus      turf_hold_scheduler_if.slave: trigger/clear requests in,
//              HOLD mask, trigger ack/index, full flag, status and dead-time
//              words out
//
//   Build option
//     HOLD_SCHED_DEADTIME_EN : when defined, counts clk33 cycles spent full
//     (saturating at 32'hFFFFFFFF) and latches the count into dead_o on each
//     PPS pulse. When undefined dead_o is constant zero.
// ---------------------------------------------------------------------------
module turf_hold_scheduler #(
    parameter int unsigned HOLDOFF = 8
) (
    input  logic                  clk33_i,
    input  logic                  rst_n_i,
    turf_hold_scheduler_if.slave  bus
);

    typedef enum logic {
        ST_IDLE,
        ST_HOLDOFF
    } state_t;

    localparam logic [7:0] HOFF_LOAD  = 8'(HOLDOFF - 1);
    localparam logic [2:0] COUNT_FULL = 3'd4;

    state_t      state_q,   state_d;
    logic [7:0]  hoff_q,    hoff_d;
    logic [1:0]  wr_ptr_q,  wr_ptr_d;
    logic [1:0]  rd_ptr_q,  rd_ptr_d;
    logic [2:0]  count_q,   count_d;
    logic [15:0] dropped_q, dropped_d;
    logic [3:0]  hold_q,    hold_d;
    logic        ack_q,     ack_d;
    logic [1:0]  buf_q,     buf_d;
    logic        full_q,    full_d;

    logic        trig_ok;
    logic        accept;
    logic        reject_full;
    logic        release_ev;

    // -----------------------------------------------------------------------
    // Request qualification, all on registered state
    // -----------------------------------------------------------------------
    always_comb begin
        trig_ok     = bus.trig_i && !bus.disable_i && (state_q == ST_IDLE);
        accept      = trig_ok && (count_q != COUNT_FULL);
        reject_full = trig_ok && (count_q == COUNT_FULL);
        release_ev  = bus.clr_evt_i && (count_q != 3'd0);
    end

    // -----------------------------------------------------------------------
    // Holdoff FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            hoff_q  <= '0;
        end else begin
            state_q <= state_d;
            hoff_q  <= hoff_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hoff_d  = hoff_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_HOLDOFF;
                    hoff_d  = HOFF_LOAD;
                end
            end
            ST_HOLDOFF: begin
                // Leaves on the cycle the counter reads zero, so accepted
                // triggers are at least HOLDOFF+1 cycles apart.
                if (hoff_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    hoff_d = hoff_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                hoff_d  = '0;
            end
        endcase
        if (bus.clr_all_i) begin
            state_d = ST_IDLE;
            hoff_d  = '0;
        end
    end

    // -----------------------------------------------------------------------
    // Buffer ring, hold mask, drop counter, output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            dropped_q <= '0;
            hold_q    <= '0;
            ack_q     <= 1'b0;
            buf_q     <= '0;
            full_q    <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
            hold_q    <= hold_d;
            ack_q     <= ack_d;
            buf_q     <= buf_d;
            full_q    <= full_d;
        end
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        dropped_d = dropped_q;
        hold_d    = hold_q;
        ack_d     = 1'b0;
        buf_d     = '0;

        // Release first: when a trigger and a clear coincide while not full,
        // wr_ptr differs from rd_ptr, so the set below never touches the
        // buffer being released. When full the trigger is rejected anyway.
        if (release_ev) begin
            hold_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 2'd1;
        end

        if (accept) begin
            hold_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = wr_ptr_q + 2'd1;
            ack_d            = 1'b1;
            buf_d            = wr_ptr_q;
        end

        unique case ({accept, release_ev})
            2'b10:   count_d = count_q + 3'd1;
            2'b01:   count_d = count_q - 3'd1;
            default: count_d = count_q;
        endcase

        if (reject_full && (dropped_q != '1)) begin
            dropped_d = dropped_q + 16'd1;
        end

        if (bus.clr_all_i) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            dropped_d = '0;
            hold_d    = '0;
            ack_d     = 1'b0;
            buf_d     = '0;
        end

        full_d = (count_d == COUNT_FULL);
    end

    assign bus.hold_o     = hold_q;
    assign bus.trig_ack_o = ack_q;
    assign bus.trig_buf_o = buf_q;
    assign bus.full_o     = full_q;
    assign bus.status_o   = {dropped_q, 8'h00, 1'b0, count_q, hold_q};

    // -----------------------------------------------------------------------
    // Optional dead-time measurement
    // -----------------------------------------------------------------------
`ifdef HOLD_SCHED_DEADTIME_EN
    logic [31:0] dead_cnt_q, dead_cnt_d;
    logic [31:0] dead_q,     dead_d;
    logic [31:0] dead_inc;

    always_ff @(posedge clk33_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dead_cnt_q <= '0;
            dead_q     <= '0;
        end else begin
            dead_cnt_q <= dead_cnt_d;
            dead_q     <= dead_d;
        end
    end

    always_comb begin
        // The PPS cycle's own full cycle is included in the latched value.
        dead_inc   = (full_q && (dead_cnt_q != '1)) ? dead_cnt_q + 32'd1 : dead_cnt_q;
        dead_cnt_d = dead_inc;
        dead_d     = dead_q;
        if (bus.pps_i) begin
            dead_d     = dead_inc;
            dead_cnt_d = '0;
        end
        if (bus.clr_all_i) begin
            dead_cnt_d = '0;
            dead_d     = '0;
        end
    end

    assign bus.dead_o = dead_q;
`else
    logic unused_pps;
    assign unused_pps = bus.pps_i;
    assign bus.dead_o = '0;
`endif

endmodule

// File: tb/tb_turf_hold_scheduler.sv
// ---------------------------------------------------------------------------
// tb_turf_hold_scheduler
//   Directed scenarios followed by random traffic. The driver steps a
//   buffer-FIFO reference model on every cycle and queues the expected
//   outputs; the monitor pops one entry after each clock edge and compares.
// ---------------------------------------------------------------------------
module tb_turf_hold_scheduler;

    localparam int unsigned HOLDOFF = 8;

    logic clk33 = 1'b0;
    logic rst_n = 1'b0;
    always #15 clk33 = ~clk33;

    turf_hold_scheduler_if bus ();

    turf_hold_scheduler #(.HOLDOFF(HOLDOFF)) dut (
        .clk33_i (clk33),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [3:0]  hold;
        logic        ack;
        logic [1:0]  bufi;
        logic        full;
        logic [31:0] status;
        logic [31:0] dead;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: the held buffers as an oldest-first list
    int     held[$];
    int     nxt;
    int     next_ok;
    int     dropped;
    int     edge_n;
    longint dead_cnt;
    longint dead_val;
    bit     m_ack;
    int     m_buf;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        held.delete();
        nxt      = 0;
        next_ok  = 0;
        dropped  = 0;
        dead_cnt = 0;
        dead_val = 0;
        m_ack    = 1'b0;
        m_buf    = 0;
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [3:0] mask;
        mask = 4'b0000;
        foreach (held[i]) mask[held[i]] = 1'b1;
        e.hold   = mask;
        e.ack    = m_ack;
        e.bufi   = 2'(m_buf);
        e.full   = (held.size() == 4);
        e.status = {16'(dropped), 8'h00, 1'b0, 3'(held.size()), mask};
`ifdef HOLD_SCHED_DEADTIME_EN
        e.dead   = 32'(dead_val);
`else
        e.dead   = 32'd0;
`endif
        return e;
    endfunction

    function automatic void model_step(bit trig, bit clr, bit clra, bit dis, bit pps);
        bit     was_full, idle, acc, drop;
        longint c;
        edge_n++;
        if (clra) begin
            model_reset();
            return;
        end
        was_full = (held.size() == 4);
        idle     = (edge_n >= next_ok);
        acc      = trig && !dis && idle && !was_full;
        drop     = trig && !dis && idle && was_full;
        c = dead_cnt + (was_full ? 1 : 0);
        if (c > 64'hFFFF_FFFF) c = 64'hFFFF_FFFF;
        if (pps) begin
            dead_val = c;
            dead_cnt = 0;
        end else begin
            dead_cnt = c;
        end
        if (clr && held.size() > 0) void'(held.pop_front());
        m_ack = acc;
        m_buf = 0;
        if (acc) begin
            m_buf = nxt;
            held.push_back(nxt);
            nxt     = (nxt + 1) % 4;
            next_ok = edge_n + int'(HOLDOFF) + 1;
        end
        if (drop && dropped < 65535) dropped++;
    endfunction

    task automatic cycle(bit trig, bit clr, bit clra, bit dis, bit pps);
        @(negedge clk33);
        bus.trig_i    = trig;
        bus.clr_evt_i = clr;
        bus.clr_all_i = clra;
        bus.disable_i = dis;
        bus.pps_i     = pps;
        model_step(trig, clr, clra, dis, pps);
        sb.push_back(model_out());
    endtask

    task automatic idle(int n);
        repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic trig_spaced(int n);
        repeat (n) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            idle(int'(HOLDOFF));
        end
    endtask

    task automatic async_reset();
        @(negedge clk33);
        bus.trig_i    = 1'b0;
        bus.clr_evt_i = 1'b0;
        bus.clr_all_i = 1'b0;
        bus.disable_i = 1'b0;
        bus.pps_i     = 1'b0;
        #5 rst_n = 1'b0;
        #1;
        chk("async_hold",   32'(bus.hold_o),     32'd0);
        chk("async_ack",    32'(bus.trig_ack_o), 32'd0);
        chk("async_full",   32'(bus.full_o),     32'd0);
        chk("async_status", bus.status_o,        32'd0);
        chk("async_dead",   bus.dead_o,          32'd0);
        rst_n = 1'b1;
        model_reset();
        edge_n++;
        sb.push_back(model_out());
    endtask

    // Monitor: one expected entry per clock edge once the driver is running
    always @(posedge clk33) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("hold",   32'(bus.hold_o),     32'(e.hold));
            chk("ack",    32'(bus.trig_ack_o), 32'(e.ack));
            if (e.ack) chk("trig_buf", 32'(bus.trig_buf_o), 32'(e.bufi));
            chk("full",   32'(bus.full_o),     32'(e.full));
            chk("status", bus.status_o,        e.status);
            chk("dead",   bus.dead_o,          e.dead);
        end
    end

    initial begin
        bus.trig_i    = 1'b0;
        bus.clr_evt_i = 1'b0;
        bus.clr_all_i = 1'b0;
        bus.disable_i = 1'b0;
        bus.pps_i     = 1'b0;
        model_reset();
        edge_n = 0;
        #1;
        chk("reset_hold",   32'(bus.hold_o), 32'd0);
        chk("reset_status", bus.status_o,    32'd0);
        chk("reset_dead",   bus.dead_o,      32'd0);
        repeat (2) @(posedge clk33);
        @(negedge clk33);
        rst_n = 1'b1;

        // Single trigger, then one inside the holdoff window
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(10);

        // Fill, drop while full, release, refill into buffer 0
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        trig_spaced(4);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(int'(HOLDOFF));

        // Coincident trigger and clear, full then half full
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        trig_spaced(2);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(int'(HOLDOFF));

        // Clear when empty, trigger while disabled
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Master clear and async reset in the middle of a holdoff window
        trig_spaced(1);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(int'(HOLDOFF));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);
        async_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(int'(HOLDOFF));

        // Dead time: full for 100 cycles, then PPS
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        trig_spaced(3);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(99);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(99) < 35, $urandom_range(99) < 15,
                  $urandom_range(999) < 8, $urandom_range(99) < 10,
                  $urandom_range(99) < 4);
        end
        idle(2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk33);
        #2;
        if (sb.size() > 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
